// File: rtl/dcache_2way.sv
// Two-way set-associative, write-back, write-allocate data cache with per-set
// LRU replacement, sitting between the MEM stage and a line-wide memory.
module dcache_2way #(
  parameter int LINE_W = 256,
  parameter int SETS   = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       p1_addr_i,
  input  logic [31:0]       p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [31:0]       mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o
);

  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 32 - OFF_W - IDX_W;
  localparam int WSEL_W = OFF_W - 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WB     = 2'b01,
    ST_REFILL = 2'b10
  } state_t;

  state_t state_r, next_s;

  logic [TAG_W-1:0]  req_tag_s;
  logic [IDX_W-1:0]  idx_s;
  logic [WSEL_W-1:0] word_s;
  logic              unused_s;

  logic [1:0]        valid_r [SETS];
  logic [1:0]        dirty_r [SETS];
  logic [SETS-1:0]   lru_r;
  logic [TAG_W-1:0]  tag_r   [2][SETS];
  logic [LINE_W-1:0] line_r  [2][SETS];

  logic              req_s, store_s;
  logic              hit0_s, hit1_s, hit_s, hit_way_s;
  logic              victim_s, victim_r;
  logic              victim_dirty_s;
  logic              miss_start_s;
  logic              retry_r;
  logic              refill_done_s;
  logic              hit_upd_s;
  logic [LINE_W-1:0] hit_line_s;
  logic [31:0]       wb_addr_s, refill_addr_s;

  logic [LINE_W-1:0] mem_data_r;
  logic [31:0]       mem_addr_r;
  logic              mem_enable_r, mem_write_r;
  logic [CNT_W-1:0]  hit_cnt_r, miss_cnt_r;

  assign req_tag_s = p1_addr_i[31:OFF_W+IDX_W];
  assign idx_s     = p1_addr_i[OFF_W+IDX_W-1:OFF_W];
  assign word_s    = p1_addr_i[OFF_W-1:2];
  // Byte offset within the word is ignored: accesses are word-aligned.
  assign unused_s  = ^p1_addr_i[1:0];

  assign req_s   = p1_MemRead_i | p1_MemWrite_i;
  assign store_s = p1_MemWrite_i;

  assign hit0_s    = valid_r[idx_s][0] && (tag_r[0][idx_s] == req_tag_s);
  assign hit1_s    = valid_r[idx_s][1] && (tag_r[1][idx_s] == req_tag_s);
  assign hit_s     = hit0_s | hit1_s;
  assign hit_way_s = hit1_s;

  assign hit_line_s = line_r[hit_way_s][idx_s];
  assign p1_data_o  = hit_line_s[{word_s, 5'd0} +: 32];
  assign p1_stall_o = req_s & ~hit_s;

  assign victim_s = (!valid_r[idx_s][0]) ? 1'b0 :
                    (!valid_r[idx_s][1]) ? 1'b1 : lru_r[idx_s];
  assign victim_dirty_s = valid_r[idx_s][victim_s] & dirty_r[idx_s][victim_s];

  assign wb_addr_s     = {tag_r[victim_s][idx_s], idx_s, {OFF_W{1'b0}}};
  assign refill_addr_s = {req_tag_s, idx_s, {OFF_W{1'b0}}};

  assign refill_done_s = (state_r == ST_REFILL) && mem_ack_i;
  assign hit_upd_s     = (state_r == ST_IDLE) && req_s && hit_s;

  // Next-state decode for the miss-handling FSM.
  always_comb begin
    next_s       = state_r;
    miss_start_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_s && !hit_s) begin
          miss_start_s = 1'b1;
          next_s       = victim_dirty_s ? ST_WB : ST_REFILL;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_WB: begin
        if (mem_ack_i) begin
          next_s = ST_REFILL;
        end else begin
          next_s = ST_WB;
        end
      end
      ST_REFILL: begin
        if (mem_ack_i) begin
          next_s = ST_IDLE;
        end else begin
          next_s = ST_REFILL;
        end
      end
      default: next_s = ST_IDLE;
    endcase
  end

  // FSM state, victim latch and retry marker.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r  <= ST_IDLE;
      victim_r <= 1'b0;
      retry_r  <= 1'b0;
    end else begin
      state_r <= next_s;
      retry_r <= refill_done_s;
      if (miss_start_s) begin
        victim_r <= victim_s;
      end
    end
  end

  // Memory-side request registers; address and victim line captured on entry.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_enable_r <= 1'b0;
      mem_write_r  <= 1'b0;
      mem_addr_r   <= 32'h0000_0000;
      mem_data_r   <= {LINE_W{1'b0}};
    end else begin
      mem_enable_r <= (next_s != ST_IDLE);
      mem_write_r  <= (next_s == ST_WB);
      case (next_s)
        ST_WB: begin
          if (state_r == ST_IDLE) begin
            mem_addr_r <= wb_addr_s;
            mem_data_r <= line_r[victim_s][idx_s];
          end
        end
        ST_REFILL: mem_addr_r <= refill_addr_s;
        default: ;
      endcase
    end
  end

  assign mem_enable_o = mem_enable_r;
  assign mem_write_o  = mem_write_r;
  assign mem_addr_o   = mem_addr_r;
  assign mem_data_o   = mem_data_r;

  // Valid, dirty and LRU bits; refill and hit updates never share a cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < SETS; i++) begin
        valid_r[i] <= 2'b00;
        dirty_r[i] <= 2'b00;
      end
      lru_r <= {SETS{1'b0}};
    end else if (refill_done_s) begin
      valid_r[idx_s][victim_r] <= 1'b1;
      dirty_r[idx_s][victim_r] <= 1'b0;
    end else if (hit_upd_s) begin
      lru_r[idx_s] <= ~hit_way_s;
      if (store_s) begin
        dirty_r[idx_s][hit_way_s] <= 1'b1;
      end
    end
  end

  // Tag and line storage; gated by valid bits, so no reset is needed here.
  always_ff @(posedge clk_i) begin
    if (refill_done_s) begin
      line_r[victim_r][idx_s] <= mem_data_i;
      tag_r[victim_r][idx_s]  <= req_tag_s;
    end else if (hit_upd_s && store_s) begin
      line_r[hit_way_s][idx_s][{word_s, 5'd0} +: 32] <= p1_data_i;
    end
  end

  // Saturating performance counters; the post-refill retry is not a hit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_cnt_r  <= {CNT_W{1'b0}};
      miss_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (hit_upd_s && !retry_r && (hit_cnt_r != {CNT_W{1'b1}})) begin
        hit_cnt_r <= hit_cnt_r + CNT_W'(1);
      end
      if (miss_start_s && (miss_cnt_r != {CNT_W{1'b1}})) begin
        miss_cnt_r <= miss_cnt_r + CNT_W'(1);
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_r;
  assign miss_cnt_o = miss_cnt_r;

endmodule

// File: tb/tb_dcache_2way.sv
// Randomized bench for dcache_2way against a cache/memory reference model kept
// as associative arrays of lines and words.
module tb_dcache_2way;
  localparam int LINE_W = 128;
  localparam int SETS   = 4;
  localparam int CNT_W  = 6;
  localparam int OFF_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [31:0]       p1_addr_i = 32'h0;
  logic [31:0]       p1_data_i = 32'h0;
  logic              p1_MemRead_i = 1'b0;
  logic              p1_MemWrite_i = 1'b0;
  logic [31:0]       p1_data_o;
  logic              p1_stall_o;
  logic [LINE_W-1:0] mem_data_i = '0;
  logic              mem_ack_i = 1'b0;
  logic [LINE_W-1:0] mem_data_o;
  logic [31:0]       mem_addr_o;
  logic              mem_enable_o;
  logic              mem_write_o;
  logic [CNT_W-1:0]  hit_cnt_o;
  logic [CNT_W-1:0]  miss_cnt_o;

  dcache_2way #(.LINE_W(LINE_W), .SETS(SETS), .CNT_W(CNT_W)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
    .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
    .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .mem_data_o(mem_data_o), .mem_addr_o(mem_addr_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: per-set ways hold a line base address; memory is sparse.
  bit                m_valid [SETS][2];
  bit                m_dirty [SETS][2];
  logic [31:0]       m_la    [SETS][2];
  logic [LINE_W-1:0] m_line  [SETS][2];
  int                m_lru   [SETS];
  int                m_hits, m_miss;
  logic [LINE_W-1:0] mem_m  [logic [31:0]];
  logic [LINE_W-1:0] init_m [logic [31:0]];
  logic [31:0]       gold   [logic [31:0]];

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic touch(input logic [31:0] la);
    logic [LINE_W-1:0] l;
    if (!mem_m.exists(la)) begin
      for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
      mem_m[la]  = l;
      init_m[la] = l;
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    logic [31:0]       wa;
    logic [LINE_W-1:0] l;
    wa = {a[31:2], 2'b00};
    if (gold.exists(wa)) return gold[wa];
    l = init_m[{a[31:OFF_W], {OFF_W{1'b0}}}];
    return l[int'(a[OFF_W-1:2])*32 +: 32];
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_valid[s][0] = 1'b0; m_valid[s][1] = 1'b0;
      m_dirty[s][0] = 1'b0; m_dirty[s][1] = 1'b0;
      m_lru[s] = 0;
    end
    m_hits = 0;
    m_miss = 0;
    gold.delete();
    foreach (mem_m[k]) init_m[k] = mem_m[k];
  endtask

  // One request, held until it completes, then one idle cycle. Starts #1 after a rising edge.
  task automatic access(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] wd,
                        input int l, input int lwb, input int extra, input bit idle_ack);
    logic [31:0]       la, vla;
    logic [LINE_W-1:0] rl;
    int                idx, w, hw, vic;
    bit                hit, wb;
    la  = {a[31:OFF_W], {OFF_W{1'b0}}};
    idx = int'(a[OFF_W+1:OFF_W]);
    w   = int'(a[OFF_W-1:2]);
    touch(la);
    p1_addr_i = a; p1_data_i = wd; p1_MemRead_i = rd; p1_MemWrite_i = wr;
    hit = 1'b0; hw = 0;
    for (int wy = 0; wy < 2; wy++)
      if (m_valid[idx][wy] && m_la[idx][wy] == la) begin hit = 1'b1; hw = wy; end
    if (!hit) begin
      vic = !m_valid[idx][0] ? 0 : (!m_valid[idx][1] ? 1 : m_lru[idx]);
      wb  = m_valid[idx][vic] && m_dirty[idx][vic];
      vla = m_la[idx][vic];
      @(negedge clk_i);
      chk("miss_stall", LINE_W'(p1_stall_o), LINE_W'(1'b1));
      chk("miss_en", LINE_W'(mem_enable_o), LINE_W'(1'b0));
      if (m_miss < CMAX) m_miss++;
      @(posedge clk_i); #1;
      if (wb) begin
        for (int k = 0; k <= lwb; k++) begin
          @(negedge clk_i);
          chk("wb_en", LINE_W'(mem_enable_o), LINE_W'(1'b1));
          chk("wb_wr", LINE_W'(mem_write_o), LINE_W'(1'b1));
          chk("wb_addr", LINE_W'(mem_addr_o), LINE_W'(vla));
          chk("wb_data", mem_data_o, m_line[idx][vic]);
          chk("wb_stall", LINE_W'(p1_stall_o), LINE_W'(1'b1));
          if (k == lwb) mem_ack_i = 1'b1;
          @(posedge clk_i); #1;
          mem_ack_i = 1'b0;
        end
        mem_m[vla] = m_line[idx][vic];
      end
      rl = mem_m[la];
      for (int k = 0; k <= l; k++) begin
        @(negedge clk_i);
        chk("rf_en", LINE_W'(mem_enable_o), LINE_W'(1'b1));
        chk("rf_wr", LINE_W'(mem_write_o), LINE_W'(1'b0));
        chk("rf_addr", LINE_W'(mem_addr_o), LINE_W'(la));
        chk("rf_stall", LINE_W'(p1_stall_o), LINE_W'(1'b1));
        mem_data_i = rl;
        if (k == l) mem_ack_i = 1'b1;
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
      end
      m_valid[idx][vic] = 1'b1; m_dirty[idx][vic] = 1'b0;
      m_la[idx][vic] = la; m_line[idx][vic] = rl;
      hw = vic;
    end
    for (int c = 0; c <= extra; c++) begin
      @(negedge clk_i);
      chk("hit_stall", LINE_W'(p1_stall_o), LINE_W'(1'b0));
      chk("hit_en", LINE_W'(mem_enable_o), LINE_W'(1'b0));
      if (!wr) chk("load_data", LINE_W'(p1_data_o), LINE_W'(exp_word(a)));
      if ((hit || c > 0) && m_hits < CMAX) m_hits++;
      m_lru[idx] = 1 - hw;
      if (wr) begin
        m_line[idx][hw][w*32 +: 32] = wd;
        m_dirty[idx][hw] = 1'b1;
        gold[{a[31:2], 2'b00}] = wd;
      end
      @(posedge clk_i); #1;
    end
    p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
    mem_ack_i = idle_ack;
    @(negedge clk_i);
    chk("idle_stall", LINE_W'(p1_stall_o), LINE_W'(1'b0));
    chk("idle_en", LINE_W'(mem_enable_o), LINE_W'(1'b0));
    chk("hit_cnt", LINE_W'(hit_cnt_o), LINE_W'(m_hits));
    chk("miss_cnt", LINE_W'(miss_cnt_o), LINE_W'(m_miss));
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b0;
    model_reset();
    p1_MemRead_i = 1'b1;
    #12;
    chk("rst_stall", LINE_W'(p1_stall_o), LINE_W'(1'b1));
    chk("rst_en", LINE_W'(mem_enable_o), LINE_W'(1'b0));
    chk("rst_wr", LINE_W'(mem_write_o), LINE_W'(1'b0));
    chk("rst_hit", LINE_W'(hit_cnt_o), LINE_W'(0));
    chk("rst_miss", LINE_W'(miss_cnt_o), LINE_W'(0));
    p1_MemRead_i = 1'b0;
    @(negedge clk_i); rst_i = 1'b1;
    @(posedge clk_i); #1;

    // Set-0 replacement scenario: 0x00, 0x40, 0x80 share a set.
    access(32'h0000_0000, 1'b1, 1'b0, 32'h0, 3, 0, 0, 1'b0);
    access(32'h0000_0000, 1'b1, 1'b0, 32'h0, 3, 0, 0, 1'b1);
    access(32'h0000_0040, 1'b1, 1'b0, 32'h0, 2, 0, 0, 1'b0);
    access(32'h0000_0000, 1'b1, 1'b0, 32'h0, 0, 0, 0, 1'b0);
    access(32'h0000_0080, 1'b1, 1'b0, 32'h0, 1, 0, 0, 1'b0);
    access(32'h0000_0000, 1'b1, 1'b0, 32'h0, 0, 0, 0, 1'b0);
    access(32'h0000_0004, 1'b0, 1'b1, 32'hDEAD_BEEF, 0, 0, 0, 1'b0);
    access(32'h0000_0040, 1'b1, 1'b0, 32'h0, 0, 0, 0, 1'b0);
    access(32'h0000_0080, 1'b1, 1'b0, 32'h0, 2, 3, 0, 1'b0);
    access(32'h0000_0004, 1'b1, 1'b0, 32'h0, 1, 0, 4, 1'b0);

    // Reset while the memory request is outstanding.
    touch(32'h0000_0F00);
    p1_addr_i = 32'h0000_0F00; p1_MemRead_i = 1'b1;
    @(negedge clk_i);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("pre_rst_en", LINE_W'(mem_enable_o), LINE_W'(1'b1));
    rst_i = 1'b0;
    #1;
    chk("mid_rst_en", LINE_W'(mem_enable_o), LINE_W'(1'b0));
    chk("mid_rst_hit", LINE_W'(hit_cnt_o), LINE_W'(0));
    chk("mid_rst_miss", LINE_W'(miss_cnt_o), LINE_W'(0));
    p1_MemRead_i = 1'b0;
    @(negedge clk_i); rst_i = 1'b1;
    model_reset();
    @(posedge clk_i); #1;
    access(32'h0000_0000, 1'b1, 1'b0, 32'h0, 3, 0, 0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      int          rw;
      a  = {(($urandom_range(0, 3) == 0) ? 8'hA5 : 8'h00), 16'h0000,
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      rw = $urandom_range(0, 2);
      access(a, (rw != 1), (rw != 0), $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
             ($urandom_range(0, 3) == 0) ? 2 : 0, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dcache_2way.md
# dcache_2way

Two-way set-associative, write-back, write-allocate data cache with per-set LRU replacement and saturating hit/miss counters. It sits between the pipeline's MEM stage (p1_* port) and the line-wide data memory (mem_* port), and is a drop-in successor to the direct-mapped data cache. Line width and set count are parameters.

## Interface
- LINE_W, 256: line width in bits; power of two, multiple of 32, at least 64.
- SETS, 32: number of sets; power of two, at least 2. OFF_W = log2(LINE_W/8), IDX_W = log2(SETS), TAG_W = 32-OFF_W-IDX_W.
- CNT_W, 32: performance counter width.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- p1_addr_i  in  32  byte address; word-aligned (bits [1:0] ignored).
- p1_data_i  in  32  store data.
- p1_MemRead_i  in  1  load request.
- p1_MemWrite_i  in  1  store request; if both requests are high, the access is a store.
- p1_data_o  out  32  load data; valid when a request is present and p1_stall_o=0.
- p1_stall_o  out  1  high while the request has not completed.
- mem_data_i  in  LINE_W  refill line.
- mem_ack_i  in  1  one-cycle completion pulse for the current memory request.
- mem_data_o  out  LINE_W  write-back line.
- mem_addr_o  out  32  line address; bits [OFF_W-1:0] are 0.
- mem_enable_o  out  1  memory request active.
- mem_write_o  out  1  1 = write-back, 0 = refill.
- hit_cnt_o  out  CNT_W  saturating count of first-try hits.
- miss_cnt_o  out  CNT_W  saturating count of misses.

## Operation
- Address split: tag = addr[31:OFF_W+IDX_W], index = addr[OFF_W+IDX_W-1:OFF_W], word = addr[OFF_W-1:2].
- Each way of each set holds valid, dirty, tag and a line. Each set holds one LRU bit naming the way to evict next.
- Storage is internal flop/array. Reads are combinational on the index.
- Hit: a way has valid=1 and a matching tag; at most one way can hit.
  - p1_data_o = the selected word of the hit way, combinational.
  - On a store hit, the clock edge writes p1_data_i into that word and sets dirty=1.
  - Any hit sets LRU to the other way.
- With no request: p1_stall_o=0, no state changes, p1_data_o don't-care.
- States:
  - IDLE. With a request and no hit, latch the victim way and go to WB if the victim is valid and dirty, otherwise to REFILL. Victim choice: way 0 if invalid; else way 1 if invalid; else the LRU way.
  - WB. mem_enable_o=1, mem_write_o=1, mem_addr_o = {victim tag, index, 0}, mem_data_o = victim line. On mem_ack_i, go to REFILL.
  - REFILL. mem_enable_o=1, mem_write_o=0, mem_addr_o = {request tag, index, 0}. On mem_ack_i, write mem_data_i, the tag, valid=1 and dirty=0 into the victim way, then go to IDLE.
- After REFILL the request hits in IDLE and completes as a normal hit; a store gets merged there.
- p1_stall_o = request & !hit, evaluated in every state, so it is high throughout WB and REFILL.
- Outside WB and REFILL: mem_enable_o=0, mem_write_o=0, mem_addr_o and mem_data_o don't-care.
- The CPU holds p1_addr_i, p1_data_i and the request flags stable while p1_stall_o=1. Changing them mid-miss is illegal.
- Counters:
  - miss_cnt increments on each IDLE→WB or IDLE→REFILL transition.
  - hit_cnt increments on each IDLE cycle with a request and a hit, except the first IDLE cycle after REFILL (the retry).
  - Each counter holds at all-ones.
  - A request held for N hit cycles counts N hits.

## Timing
- Reset (asynchronous, active-low):
  - state = IDLE; every valid, dirty and LRU bit = 0; both counters = 0.
  - mem_enable_o=0, mem_write_o=0; p1_stall_o = request present.
  - A reset during WB or REFILL abandons the memory transaction, and dirty data is lost.
- Hit latency: 0 cycles of stall. Store data is visible to a load on the next cycle.
- Clean miss, memory ack L cycles after mem_enable_o rises:
  - mem_enable_o rises at the edge after the miss is seen.
  - Stall lasts L+2 cycles.
  - The line is written on the ack edge; the following IDLE cycle hits and drops stall.
- Dirty miss: WB adds L_wb+1 cycles. mem_enable_o stays high across the WB→REFILL boundary; mem_write_o falls at that edge.
- mem_ack_i while mem_enable_o=0 is ignored. Each ack completes exactly one request.
- A miss and a hit cannot coincide. The LRU and counter updates of a hit and a refill never occur in the same cycle.

## Test plan
- Defaults, memory latency 3. Load 0x000 → miss_cnt=1, stall 5 cycles, mem_addr_o=0x000 with write=0, p1_data_o = word 0 of the returned line. Load again → 0 stall, hit_cnt=1.
- Load 0x000, then 0x400, both set 0 → 2 misses, both ways valid. Load 0x000 → hit, LRU=1. Load 0x800 → evicts way 1 (0x400), no write-back. Load 0x000 → hit.
- Store 0xDEADBEEF to 0x004 (miss, allocate). Load 0x400, then load 0x800 → the 0x000 line is LRU and dirty. Expect mem_write_o=1, mem_addr_o=0x000, mem_data_o word 1 = 0xDEADBEEF, then a refill from 0x800.
- Assert reset mid-REFILL → mem_enable_o=0 immediately, counters 0. Load 0x000 → miss again.
- Same cycle-free sequence with SETS=4, LINE_W=128: addresses 0x00, 0x40, 0x80 map to set 0. Repeat the eviction scenario.
- Set CNT_W=2 and issue 5 hits → hit_cnt_o stays at 3.
